// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial bit-sequence detector with a run-time programmable SEQ_LEN-bit
//   pattern. Emits a registered one-cycle `detected` pulse on every match,
//   in either overlapping or non-overlapping mode.
//
//   Optional feature macro: SEQ_DETECT_CNT_EN
//     defined   -> saturating match counter and cnt_clr are built in
//     undefined -> match_cnt is tied to 0, cnt_clr is ignored
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   data_valid in   1        qualifies `data`
//   data       in   1        serial input bit
//   pat_wr     in   1        load strobe for pat_in (also restarts the window)
//   pat_in     in   SEQ_LEN  new pattern, bit 0 = first bit expected
//   overlap    in   1        1 = overlapping matches, 0 = non-overlapping
//   cnt_clr    in   1        synchronous clear of match_cnt
//   detected   out  1        one-cycle match pulse
//   match_cnt  out  CNT_W    saturating match count
//   state      out  2        FSM state (0 EMPTY, 1 FILL, 2 FULL)
module seq_detect_param #(
  parameter int                 SEQ_LEN         = 4,
  parameter logic [SEQ_LEN-1:0] DEFAULT_PATTERN = 4'b1001,
  parameter int                 CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_valid,
  input  logic               data,
  input  logic               pat_wr,
  input  logic [SEQ_LEN-1:0] pat_in,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [1:0]         state
);

  localparam int             FW       = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(SEQ_LEN);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic [SEQ_LEN-1:0] r_pat,   w_pat_n;
  logic [SEQ_LEN-1:0] r_hist,  w_hist_n;
  logic [FW-1:0]      r_fill,  w_fill_n;
  logic               r_det;

  logic [SEQ_LEN-1:0] w_hist_sh;
  logic [FW-1:0]      w_fill_inc;
  logic               w_match;

  // Window after accepting the current bit; hist[0] is always the oldest.
  assign w_hist_sh  = {data, r_hist[SEQ_LEN-1:1]};
  assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

  // A pattern load discards the coincident data bit, and the illegal state
  // only recovers, so neither can produce a match.
  assign w_match = data_valid && !pat_wr && (r_state != ST_BAD) &&
                   (w_fill_inc == FILL_MAX) && (w_hist_sh == r_pat);

  always_comb begin
    w_state_n = r_state;
    w_pat_n   = r_pat;
    w_hist_n  = r_hist;
    w_fill_n  = r_fill;
    if (pat_wr) begin
      w_pat_n   = pat_in;
      w_hist_n  = '0;
      w_fill_n  = '0;
      w_state_n = ST_EMPTY;
    end else if (r_state == ST_BAD) begin
      w_hist_n  = '0;
      w_fill_n  = '0;
      w_state_n = ST_EMPTY;
    end else if (data_valid) begin
      w_hist_n = w_hist_sh;
      if (w_match && !overlap) begin
        w_fill_n  = '0;
        w_state_n = ST_EMPTY;
      end else begin
        w_fill_n  = w_fill_inc;
        w_state_n = (w_fill_inc == FILL_MAX) ? ST_FULL : ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_pat   <= DEFAULT_PATTERN;
      r_hist  <= '0;
      r_fill  <= '0;
      r_det   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pat   <= w_pat_n;
      r_hist  <= w_hist_n;
      r_fill  <= w_fill_n;
      r_det   <= w_match;
    end
  end

  assign detected = r_det;
  assign state    = r_state;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over count, but a match in the clearing cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  localparam int N     = 4;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [N-1:0] DEF = 4'b1001;
`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_valid = 1'b0;
  logic          data = 1'b0;
  logic          pat_wr = 1'b0;
  logic [N-1:0]  pat_in = '0;
  logic          overlap = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          detected;
  logic [CW-1:0] match_cnt;
  logic [1:0]    state;

  seq_detect_param #(.SEQ_LEN(N), .DEFAULT_PATTERN(DEF), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data(data),
    .pat_wr(pat_wr), .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
    .detected(detected), .match_cnt(match_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int cnt; } det_t;
  typedef struct { int st;  int cnt; } cyc_t;
  det_t dq[$];
  cyc_t sq[$];

  int ntests = 0;
  int nfail  = 0;
  int npulse = 0;

  // Reference model: list of accepted bits since the last restart.
  bit            win[$];
  logic [N-1:0]  mpat = DEF;
  int            mcnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit d, input bit ov,
                      input bit pw = 1'b0, input bit [N-1:0] pin = '0,
                      input bit clr = 1'b0);
    bit m;
    int st;
    @(negedge clk);
    data_valid = v; data = d; overlap = ov;
    pat_wr = pw; pat_in = pin; cnt_clr = clr;
    m = 1'b0;
    if (pw) begin
      mpat = pin;
      win.delete();
    end else if (v) begin
      win.push_back(d);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        m = 1'b1;
        foreach (win[i]) if (win[i] != mpat[i]) m = 1'b0;
      end
      if (m && !ov) win.delete();
    end
    if (CNT_EN) begin
      if (clr) mcnt = m ? 1 : 0;
      else if (m && mcnt < CMAX) mcnt++;
    end
    st = (win.size() == 0) ? 0 : ((win.size() < N) ? 1 : 2);
    sq.push_back('{st, mcnt});
    if (m) dq.push_back('{cyc + 1, mcnt});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, overlap);
  endtask

  task automatic feed(input logic [15:0] bits, input int len, input bit ov);
    for (int i = 0; i < len; i++) step(1'b1, bits[i], ov);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_detected", int'(detected), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    chk("rst_state", int'(state), 0);
    win.delete(); mcnt = 0; mpat = DEF;
    dq.delete(); sq.delete();
    @(negedge clk);
    data_valid = 1'b0; pat_wr = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle state/count queue plus detection-event scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (sq.size() > 0) begin
        cyc_t e;
        e = sq.pop_front();
        chk("state", int'(state), e.st);
        chk("match_cnt", int'(match_cnt), e.cnt);
      end
      if (detected) begin
        npulse++;
        if (dq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          det_t x;
          x = dq.pop_front();
          chk("pulse_cycle", cyc, x.cyc);
          chk("pulse_cnt", int'(match_cnt), x.cnt);
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        chk("missed_pulse_cycle", cyc, -1);
        void'(dq.pop_front());
      end
    end
  end

  int p0;
  logic [15:0] s;

  initial begin
    #1;
    chk("init_detected", int'(detected), 0);
    chk("init_match_cnt", int'(match_cnt), 0);
    chk("init_state", int'(state), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern, non-overlap, 1,0,0,1
    p0 = npulse;
    s = 16'b1001;
    feed(s, 4, 1'b0);
    idle(2);
    chk("A_pulses", npulse - p0, 1);
    chk("A_cnt", int'(match_cnt), CNT_EN ? 1 : 0);
    chk("A_state", int'(state), 0);

    // 1,0,0,1,0,0,1 overlap -> two pulses
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b1);
    p0 = npulse;
    s = 16'b1001001;
    feed(s, 7, 1'b1);
    idle(2);
    chk("B_pulses_ov", npulse - p0, 2);

    // Same stream non-overlap -> one pulse
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1001);
    p0 = npulse;
    feed(s, 7, 1'b0);
    idle(2);
    chk("C_pulses_nov", npulse - p0, 1);

    // Pattern 1111, six 1s, overlap -> 3 consecutive pulses
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    p0 = npulse;
    s = 16'h003F;
    feed(s, 6, 1'b1);
    idle(2);
    chk("D_pulses", npulse - p0, 3);
    chk("D_cnt", int'(match_cnt), CNT_EN ? 3 : 0);

    // data_valid toggled between bits
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1);
    p0 = npulse;
    step(1'b1, 1'b1, 1'b0); idle(1);
    step(1'b1, 1'b0, 1'b0); idle(1);
    step(1'b1, 1'b0, 1'b0); idle(1);
    step(1'b1, 1'b1, 1'b0); idle(3);
    chk("E_pulses", npulse - p0, 1);

    // Saturation with eight matches, then clear on a match cycle
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    s = 16'h07FF;
    feed(s, 11, 1'b1);
    idle(1);
    chk("F_sat_cnt", int'(match_cnt), CNT_EN ? CMAX : 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    idle(1);
    chk("F_clr_on_match", int'(match_cnt), CNT_EN ? 1 : 0);

    // pat_wr after bit 3 discards the window and the coincident bit
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1);
    p0 = npulse;
    s = 16'b001;
    feed(s, 3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1001);
    idle(2);
    chk("G_no_pulse", npulse - p0, 0);
    chk("G_state", int'(state), 0);
    s = 16'b1001;
    feed(s, 4, 1'b0);
    idle(2);
    chk("G_pulse_after", npulse - p0, 1);

    // Reset right after a match edge, then a partial window must not carry over
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b1);
    s = 16'b1001;
    feed(s, 4, 1'b1);
    async_reset();
    p0 = npulse;
    s = 16'b100;
    feed(s, 3, 1'b1);
    idle(2);
    chk("H_no_carry", npulse - p0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, d, ov, pw, clr;
      bit [N-1:0] pin;
      v   = ($urandom_range(0, 3) != 0);
      d   = $urandom_range(0, 1) == 1;
      ov  = (i / 50) % 2 == 1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      pw  = ($urandom_range(0, 99) == 0);
      pin = N'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      step(v, d, ov, pw, pin, clr);
    end
    idle(3);
    chk("drain_expected_pulses", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
